seg7_scanner: RTL and testbench

- Hardware display engine downstream of the data-memory display register; replaces software-driven digit multiplexing.
- CPU writes a 16-bit hex value (4 nibbles) plus a decimal-point mask.
- Block time-multiplexes the 4 digits of the board 7-segment display, decodes hex to segments and inserts anti-ghosting dead time.
- New values are double-buffered so a frame is never torn.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/seg7_decode.sv | 12 +
 rtl/seg7_scanner.sv | 106 ++++++++++
 tb/tb_seg7_scanner.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scanner: hex segment table, idle patterns,
// digit-index width.
package seg7_pkg;

    localparam int IDX_W = 2;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Active-high {g,f,e,d,c,b,a}; entry n lives at index n (entry F is listed first).
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        return SEG_HEX[nib];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble plus decimal point to active-low {dp,g,f,e,d,c,b,a}.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, ~hex_seg(nibble)};

endmodule

// File: rtl/seg7_scanner.sv
// Four-digit 7-segment scanner: slot timing, frame-synchronous double buffering,
// leading-zero blanking and registered anode/segment drive.
module seg7_scanner
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 100000,
    parameter int DEAD    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic        blank_lz,
    output logic [3:0]  AN,
    output logic [7:0]  BCD,
    output logic        frame_done
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

    logic [CW-1:0]    cnt;
    logic [IDX_W-1:0] idx;
    logic [15:0]      act_val, shd_val;
    logic [3:0]       act_dp, shd_dp;
    logic             pending;
    logic             frame_bnd;

    assign frame_bnd = (cnt == CNT_MAX) && (idx == IDX_W'(3));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A write landing on the boundary bypasses the shadow so it is not held a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_val <= '0;
            act_dp  <= '0;
            shd_val <= '0;
            shd_dp  <= '0;
            pending <= 1'b0;
        end else if (frame_bnd) begin
            if (wr_en) begin
                act_val <= wr_data;
                act_dp  <= wr_dp;
            end else if (pending) begin
                act_val <= shd_val;
                act_dp  <= shd_dp;
            end
            pending <= 1'b0;
        end else if (wr_en) begin
            shd_val <= wr_data;
            shd_dp  <= wr_dp;
            pending <= 1'b1;
        end
    end

    logic [3:0] nib;
    logic [7:0] seg;
    logic [3:0] hi_zero;
    logic       blank;
    logic       dark;

    assign nib = act_val[idx*4 +: 4];

    seg7_decode u_dec (
        .nibble (nib),
        .dp     (act_dp[idx]),
        .seg    (seg)
    );

    // hi_zero[k]: nibbles k..3 are all zero.
    always_comb begin
        hi_zero    = '0;
        hi_zero[3] = (act_val[15:12] == 4'h0);
        for (int k = 2; k >= 0; k--)
            hi_zero[k] = hi_zero[k+1] && (act_val[k*4 +: 4] == 4'h0);
    end

    assign blank = blank_lz && (idx != '0) && hi_zero[idx] && !act_dp[idx];
    assign dark  = (cnt < DEAD_CNT) || blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            AN         <= AN_OFF;
            BCD        <= SEG_OFF;
            frame_done <= 1'b0;
        end else begin
            AN         <= dark ? AN_OFF  : ~(4'b0001 << idx);
            BCD        <= dark ? SEG_OFF : seg;
            frame_done <= frame_bnd;
        end
    end

endmodule

// File: tb/tb_seg7_scanner.sv
// Scoreboard bench for seg7_scanner (CLK_DIV=8, DEAD=2): a cycle model queues the
// expected registered outputs at each edge; they are compared on the next falling edge.
module tb_seg7_scanner;

    localparam int CLK_DIV = 8;
    localparam int DEAD    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic [3:0]  wr_dp = '0;
    logic        blank_lz = 1'b0;
    logic [3:0]  AN;
    logic [7:0]  BCD;
    logic        frame_done;

    seg7_scanner #(.CLK_DIV(CLK_DIV), .DEAD(DEAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .blank_lz   (blank_lz),
        .AN         (AN),
        .BCD        (BCD),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] bcd;
        logic       fd;
    } exp_t;

    exp_t q[$];

    logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int          m_cnt, m_idx;
    logic [15:0] m_val, m_sval;
    logic [3:0]  m_dp, m_sdp;
    logic        m_pend;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_idx = 0; m_val = '0; m_sval = '0;
            m_dp = '0; m_sdp = '0; m_pend = 1'b0;
            q.delete();
        end else begin
            exp_t e;
            logic bnd, blk;
            logic [3:0] nb;
            bnd = (m_cnt == CLK_DIV-1) && (m_idx == 3);
            nb  = 4'((m_val >> (4*m_idx)) & 16'hF);
            blk = blank_lz && (m_idx != 0) && ((m_val >> (4*m_idx)) == 16'h0) && !m_dp[m_idx];
            if (m_cnt < DEAD || blk) begin
                e.an = 4'hF; e.bcd = 8'hFF;
            end else begin
                e.an  = 4'hF & ~(4'h1 << m_idx);
                e.bcd = {~m_dp[m_idx], ~hex_tbl[nb]};
            end
            e.fd = bnd;
            q.push_back(e);
            if (bnd && wr_en) begin
                m_val = wr_data; m_dp = wr_dp; m_pend = 1'b0;
            end else if (bnd && m_pend) begin
                m_val = m_sval; m_dp = m_sdp; m_pend = 1'b0;
            end else if (wr_en) begin
                m_sval = wr_data; m_sdp = wr_dp; m_pend = 1'b1;
            end
            if (m_cnt == CLK_DIV-1) begin
                m_cnt = 0; m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_an", 32'(AN), 32'hF);
            chk("rst_bcd", 32'(BCD), 32'hFF);
            chk("rst_fd", 32'(frame_done), 32'h0);
        end else if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("an", 32'(AN), 32'(e.an));
            chk("bcd", 32'(BCD), 32'(e.bcd));
            chk("frame_done", 32'(frame_done), 32'(e.fd));
            chk("an_onehot", 32'($countones(~AN) <= 1), 32'h1);
        end
    end

    // Leaves the bench at a falling edge where the DUT holds cnt==c, idx==i.
    task automatic wait_state(input int i, input int c, input string tag);
        bit found = 0;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (m_idx == i && m_cnt == c) found = 1;
        end
        chk({"wait_", tag}, 32'(found), 32'h1);
    endtask

    task automatic do_write(input logic [15:0] d, input logic [3:0] dp);
        wr_data = d; wr_dp = dp; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #1 reset = 1'b1;
        run(3);
        #2 reset = 1'b0;

        run(70);                                 // idle frames showing 0000

        wait_state(1, 3, "mid1");
        do_write(16'h12AF, 4'b0100);
        run(70);

        wait_state(3, CLK_DIV-1, "bnd");         // write exactly on the boundary
        do_write(16'h0005, 4'b0000);
        run(70);

        blank_lz = 1'b1;
        wait_state(1, 2, "mid2");
        do_write(16'h0050, 4'b0000);
        run(70);
        wait_state(0, 5, "mid3");
        do_write(16'h0050, 4'b1000);
        run(70);

        blank_lz = 1'b0;
        wait_state(0, 4, "mid4");
        do_write(16'h1111, 4'b0000);
        run(5);
        do_write(16'h2222, 4'b0000);
        run(70);

        wait_state(2, 4, "idx2");
        #2 reset = 1'b1;
        #1;
        chk("async_an", 32'(AN), 32'hF);
        chk("async_bcd", 32'(BCD), 32'hFF);
        chk("async_fd", 32'(frame_done), 32'h0);
        run(2);
        #2 reset = 1'b0;
        run(70);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
